// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: one-word hold buffer feeding a shift register, one bit per DIV clocks.
// Optional feature: define PARITY_EN to append a parity bit (sense set by ODD_PARITY) to each word.
module bit_serializer #(
  parameter int DATA_W     = 8,
  parameter int DIV        = 1,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_BIT   = 1'b1,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              dout,
  output logic              dout_en,
  output logic              busy
);
  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BCW = $clog2(DATA_W);
  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_W - 1);

`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t            state, state_d;
  logic [DATA_W-1:0] hold, hold_d, shreg, shreg_d;
  logic              hold_full, hold_full_d;
  logic [DCW-1:0]    div_cnt, div_d;
  logic [BCW-1:0]    bit_cnt, bit_d;
  logic              dout_d, en_d;
  logic              take, word_done;
`ifdef PARITY_EN
  logic              par_bit, par_d;
`endif

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  assign data_ready = !hold_full;
  assign busy       = (state != IDLE) || hold_full;

  always_comb begin
    state_d   = state;
    shreg_d   = shreg;
    div_d     = div_cnt;
    bit_d     = bit_cnt;
    dout_d    = dout;
    en_d      = 1'b0;
    take      = 1'b0;
    word_done = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) begin
          take    = 1'b1;
          state_d = SHIFT;
          shreg_d = hold;
          dout_d  = first_bit(hold);
          en_d    = 1'b1;
          div_d   = '0;
          bit_d   = '0;
        end else begin
          dout_d = IDLE_BIT;
        end
      end
      SHIFT: begin
        if (div_cnt != DIV_LAST) begin
          div_d = div_cnt + 1'b1;
        end else if (bit_cnt != BIT_LAST) begin
          div_d   = '0;
          bit_d   = bit_cnt + 1'b1;
          shreg_d = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
          dout_d  = MSB_FIRST ? shreg[DATA_W-2] : shreg[1];
          en_d    = 1'b1;
        end else begin
`ifdef PARITY_EN
          state_d = PARITY;
          div_d   = '0;
          bit_d   = '0;
          dout_d  = par_bit;
          en_d    = 1'b1;
`else
          word_done = 1'b1;
`endif
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (div_cnt != DIV_LAST) div_d = div_cnt + 1'b1;
        else                     word_done = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
    // End of a word: chain straight into the buffered word so the stream has no gap.
    if (word_done) begin
      div_d = '0;
      bit_d = '0;
      if (hold_full) begin
        take    = 1'b1;
        state_d = SHIFT;
        shreg_d = hold;
        dout_d  = first_bit(hold);
        en_d    = 1'b1;
      end else begin
        state_d = IDLE;
        dout_d  = IDLE_BIT;
      end
    end
  end

  always_comb begin
    hold_d      = hold;
    hold_full_d = hold_full;
    if (take) begin
      hold_full_d = 1'b0;
    end else if (data_valid && !hold_full) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end
  end

`ifdef PARITY_EN
  always_comb begin
    par_d = par_bit;
    if (take) par_d = (^hold) ^ ODD_PARITY;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
      shreg     <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      dout      <= IDLE_BIT;
      dout_en   <= 1'b0;
`ifdef PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      hold      <= hold_d;
      hold_full <= hold_full_d;
      shreg     <= shreg_d;
      div_cnt   <= div_d;
      bit_cnt   <= bit_d;
      dout      <= dout_d;
      dout_en   <= en_d;
`ifdef PARITY_EN
      par_bit   <= par_d;
`endif
    end
  end
endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: two instances (DIV=1 MSB-first, DIV=3 LSB-first) against a
// timeline model that derives each cycle's bit from the word's position in its bit period.
module tb_bit_serializer;
  localparam int W = 8;
`ifdef PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] din0, din1;
  logic v0, v1, rdy0, rdy1, do0, do1, en0, en1, bz0, bz1;

  bit_serializer #(.DATA_W(W), .DIV(1), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1), .ODD_PARITY(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .data_in(din0), .data_valid(v0), .data_ready(rdy0),
    .dout(do0), .dout_en(en0), .busy(bz0));

  bit_serializer #(.DATA_W(W), .DIV(3), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0), .ODD_PARITY(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .data_in(din1), .data_valid(v1), .data_ready(rdy1),
    .dout(do1), .dout_en(en1), .busy(bz1));

  function automatic int divof(input int i);  return (i == 0) ? 1 : 3; endfunction
  function automatic bit msbf(input int i);   return (i == 0);         endfunction
  function automatic bit idleb(input int i);  return (i == 0);         endfunction
  function automatic bit oddp(input int i);   return (i != 0);         endfunction

  int       m_t[2];
  bit       m_act[2], m_hf[2];
  logic [W-1:0] m_hold[2], m_word[2];
  logic [W-1:0] pend0[$], pend1[$];
  logic     bits0[$];
  int       errors = 0;
  int       checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_dout(input int i);
    int k;
    if (!m_act[i]) return idleb(i);
    k = m_t[i] / divof(i);
    if (k < W) return msbf(i) ? m_word[i][W-1-k] : m_word[i][k];
    return (^m_word[i]) ^ oddp(i);
  endfunction

  task automatic check_all(input string ph);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s.dout%0d", ph, i), (i == 0) ? do0 : do1, exp_dout(i));
      chk($sformatf("%s.dout_en%0d", ph, i), (i == 0) ? en0 : en1,
          m_act[i] && (m_t[i] % divof(i) == 0));
      chk($sformatf("%s.ready%0d", ph, i), (i == 0) ? rdy0 : rdy1, !m_hf[i]);
      chk($sformatf("%s.busy%0d", ph, i), (i == 0) ? bz0 : bz1, m_act[i] || m_hf[i]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 1'b0;
      m_hf[i]  = 1'b0;
      m_t[i]   = 0;
    end
  endtask

  task automatic drive();
    v0   = (pend0.size() > 0);
    din0 = v0 ? pend0[0] : W'($urandom);
    v1   = (pend1.size() > 0);
    din1 = v1 ? pend1[0] : W'($urandom);
  endtask

  task automatic step();
    bit hs[2];
    logic [W-1:0] d[2];
    int p;
    hs[0] = v0 && !m_hf[0];
    hs[1] = v1 && !m_hf[1];
    d[0]  = din0;
    d[1]  = din1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      p = (W + PB) * divof(i);
      if (m_act[i]) begin
        if (m_t[i] == p - 1) begin
          if (m_hf[i]) begin m_word[i] = m_hold[i]; m_t[i] = 0; m_hf[i] = 1'b0; end
          else m_act[i] = 1'b0;
        end else m_t[i]++;
      end else if (m_hf[i]) begin
        m_act[i] = 1'b1; m_word[i] = m_hold[i]; m_t[i] = 0; m_hf[i] = 1'b0;
      end
      if (hs[i]) begin m_hold[i] = d[i]; m_hf[i] = 1'b1; end
    end
    if (hs[0]) void'(pend0.pop_front());
    if (hs[1]) void'(pend1.pop_front());
    if (en0) bits0.push_back(do0);
    check_all("run");
    drive();
  endtask

  // Reset asserted mid-cycle: outputs must drop to their reset values before any edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    rst_n = 1'b1;
    drive();
  endtask

  initial begin
    logic [2*(W+PB)-1:0] exp_a;
    logic [W-1:0] exp_b;
    v0 = 1'b0; v1 = 1'b0; din0 = '0; din1 = '0;
    model_reset();
    #12;
    check_all("reset");
    v0 = 1'b1; v1 = 1'b1;
    @(posedge clk);
    #1;
    check_all("reset_ignore_hs");
    rst_n = 1'b1;
    drive();

    // Back-to-back words must form one contiguous stream.
    bits0.delete();
    pend0.push_back(8'hA5); pend0.push_back(8'h3C);
    pend1.push_back(8'hA5); pend1.push_back(8'h3C);
    drive();
    repeat (64) step();
`ifdef PARITY_EN
    exp_a = {8'hA5, 1'b0, 8'h3C, 1'b0};
`else
    exp_a = {8'hA5, 8'h3C};
`endif
    chk("A.nbits", bits0.size(), 2 * (W + PB));
    for (int k = 0; k < 2 * (W + PB); k++)
      chk($sformatf("A.bit%0d", k), (k < bits0.size()) ? bits0[k] : 1'bx, exp_a[2*(W+PB)-1-k]);

    // Reset after the 3rd bit of FF with 00 buffered; next word restarts from its MSB.
    pend0.push_back(8'hFF); pend0.push_back(8'h00);
    drive();
    repeat (4) step();
    do_reset();
    bits0.delete();
    pend0.push_back(8'h0F);
    drive();
    repeat (16) step();
    exp_b = 8'h0F;
    chk("B.nbits", bits0.size(), W + PB);
    for (int k = 0; k < W; k++)
      chk($sformatf("B.bit%0d", k), (k < bits0.size()) ? bits0[k] : 1'bx, exp_b[W-1-k]);

    // Random traffic with gaps, streaming and occasional resets.
    for (int n = 0; n < 600; n++) begin
      if (pend0.size() < 2 && $urandom_range(0, 2) == 0) pend0.push_back(W'($urandom));
      if (pend1.size() < 2 && $urandom_range(0, 5) == 0) pend1.push_back(W'($urandom));
      drive();
      if ($urandom_range(0, 199) == 0) do_reset();
      else step();
    end
    repeat (70) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
